hsv_core_mem_counters: RTL and testbench

// - Bookkeeping/sequencing controller for hsv_core_mem_request. Owns the pending_reads,

---
 rtl/hsv_core_mem_counters.sv | 146 ++++++++++++++
 tb/tb_hsv_core_mem_counters.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_mem_counters.sv
// hsv_core_mem_counters: outstanding read/write counters, store write balance and fence drain FSM.
// Latency: all outputs registered, one cycle after the inputs; fence_ready >= 2 cycles after fence_valid.
// Backpressure: none; inputs are single-cycle event pulses. Macro HSV_CORE_MEM_COUNTERS_PERF_EN adds perf counters.

package hsv_core_mem_counters_pkg;
  typedef logic [4:0] mem_counter;
endpackage

module hsv_core_mem_counters
  import hsv_core_mem_counters_pkg::*;
#(
  parameter int MAX_PENDING = 15
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        flush,
  input  logic        pending_reads_up,
  input  logic        pending_writes_up,
  input  logic        write_balance_down,
  input  logic        read_done,
  input  logic        write_done,
  input  logic        commit_store,
  input  logic        fence_valid,
  output logic        fence_ready,
  output mem_counter  pending_reads,
  output mem_counter  pending_writes,
  output mem_counter  write_balance,
  output logic        reads_full,
  output logic        writes_full,
  output logic        count_error
`ifdef HSV_CORE_MEM_COUNTERS_PERF_EN
  ,
  output logic [31:0] perf_fence_cycles,
  output logic [31:0] perf_full_cycles
`endif
);

  localparam mem_counter MAX_CNT = mem_counter'(MAX_PENDING);
  localparam mem_counter ONE     = mem_counter'(1);

  typedef enum logic [1:0] {FENCE_IDLE, FENCE_DRAIN, FENCE_DONE} fence_state_t;

  fence_state_t fence_state;
  mem_counter   reads_nxt;
  mem_counter   writes_nxt;
  mem_counter   balance_nxt;
  logic         reads_err;
  logic         writes_err;

  // Saturating step: an up with no done at the ceiling, or a done with no up at zero, holds.
  function automatic mem_counter step_cnt(input mem_counter cur, input logic up, input logic dn);
    mem_counter nxt;
    nxt = cur;
    if (up && !dn && cur != MAX_CNT) nxt = cur + ONE;
    else if (dn && !up && cur != '0) nxt = cur - ONE;
    return nxt;
  endfunction

  function automatic logic step_err(input mem_counter cur, input logic up, input logic dn);
    return (up && !dn && cur == MAX_CNT) || (dn && !up && cur == '0);
  endfunction

  // Next values of the outstanding-transaction counters and their error conditions.
  always_comb begin
    reads_nxt  = step_cnt(pending_reads, pending_reads_up, read_done);
    reads_err  = step_err(pending_reads, pending_reads_up, read_done);
    writes_nxt = step_cnt(pending_writes, pending_writes_up, write_done);
    writes_err = step_err(pending_writes, pending_writes_up, write_done);
  end

  // Next write balance: two's complement, flush wins over any store event that cycle.
  always_comb begin
    balance_nxt = write_balance;
    if (flush) balance_nxt = '0;
    else if (commit_store && !write_balance_down) balance_nxt = write_balance + ONE;
    else if (!commit_store && write_balance_down) balance_nxt = write_balance - ONE;
  end

  // Counter registers; full flags come from the next value so they line up with the counter.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      pending_reads  <= '0;
      pending_writes <= '0;
      write_balance  <= '0;
      reads_full     <= 1'b0;
      writes_full    <= 1'b0;
      count_error    <= 1'b0;
    end else begin
      pending_reads  <= reads_nxt;
      pending_writes <= writes_nxt;
      write_balance  <= balance_nxt;
      reads_full     <= (reads_nxt == MAX_CNT);
      writes_full    <= (writes_nxt == MAX_CNT);
      count_error    <= count_error | reads_err | writes_err;
    end
  end

  // Fence drain FSM: wait until every earlier read and write has completed, then pulse fence_ready.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      fence_state <= FENCE_IDLE;
      fence_ready <= 1'b0;
    end else if (flush) begin
      fence_state <= FENCE_IDLE;
      fence_ready <= 1'b0;
    end else begin
      case (fence_state)
        FENCE_IDLE: begin
          fence_ready <= 1'b0;
          if (fence_valid && !fence_ready) fence_state <= FENCE_DRAIN;
        end
        FENCE_DRAIN: begin
          if (!fence_valid) begin
            // Fence vanished from the request FIFO; nothing left to acknowledge.
            fence_state <= FENCE_IDLE;
          end else if (reads_nxt == '0 && writes_nxt == '0) begin
            fence_state <= FENCE_DONE;
            fence_ready <= 1'b1;
          end
        end
        FENCE_DONE: begin
          fence_state <= FENCE_IDLE;
          fence_ready <= 1'b0;
        end
        default: begin
          fence_state <= FENCE_IDLE;
          fence_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef HSV_CORE_MEM_COUNTERS_PERF_EN
  // Wrapping perf counters: cycles spent draining a fence and cycles with a full counter.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      perf_fence_cycles <= '0;
      perf_full_cycles  <= '0;
    end else begin
      if (fence_state == FENCE_DRAIN) perf_fence_cycles <= perf_fence_cycles + 32'd1;
      if (reads_full || writes_full)  perf_full_cycles  <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hsv_core_mem_counters.sv
// tb_hsv_core_mem_counters: directed stimulus for hsv_core_mem_counters with an expectation queue.
// Latency: expectations are queued as each cycle is driven and popped one clock later.
// Backpressure: not applicable; the bench drives free-running single-cycle pulses.

module tb_hsv_core_mem_counters;
  import hsv_core_mem_counters_pkg::*;

  localparam int MAXP = 15;

  logic       clk_core = 1'b0;
  logic       rst_core_n;
  logic       flush, pending_reads_up, pending_writes_up, write_balance_down;
  logic       read_done, write_done, commit_store, fence_valid;
  logic       fence_ready, reads_full, writes_full, count_error;
  mem_counter pending_reads, pending_writes, write_balance;

  typedef struct {
    string tag;
    int    rd;
    int    wr;
    int    wb;
    bit    err;
    bit    fr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  hsv_core_mem_counters #(.MAX_PENDING(MAXP)) dut (
    .clk_core           (clk_core),
    .rst_core_n         (rst_core_n),
    .flush              (flush),
    .pending_reads_up   (pending_reads_up),
    .pending_writes_up  (pending_writes_up),
    .write_balance_down (write_balance_down),
    .read_done          (read_done),
    .write_done         (write_done),
    .commit_store       (commit_store),
    .fence_valid        (fence_valid),
    .fence_ready        (fence_ready),
    .pending_reads      (pending_reads),
    .pending_writes     (pending_writes),
    .write_balance      (write_balance),
    .reads_full         (reads_full),
    .writes_full        (writes_full),
    .count_error        (count_error)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int rd, input int wr, input int wb, input bit err, input bit fr);
    exp_t e;
    e.tag = tag; e.rd = rd; e.wr = wr; e.wb = wb; e.err = err; e.fr = fr;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t       e;
    mem_counter wb_exp;
    e = sb.pop_front();
    wb_exp = mem_counter'(e.wb);
    chk(e.tag, "pending_reads",  32'(pending_reads),  32'(e.rd));
    chk(e.tag, "pending_writes", 32'(pending_writes), 32'(e.wr));
    chk(e.tag, "write_balance",  32'(write_balance),  32'(wb_exp));
    chk(e.tag, "reads_full",     32'(reads_full),     32'(e.rd == MAXP));
    chk(e.tag, "writes_full",    32'(writes_full),    32'(e.wr == MAXP));
    chk(e.tag, "count_error",    32'(count_error),    32'(e.err));
    chk(e.tag, "fence_ready",    32'(fence_ready),    32'(e.fr));
  endtask

  // Drive this cycle's pulses: flush, rd_up, wr_up, wb_down, rd_done, wr_done, commit, fence_valid.
  task automatic drive(input bit fl, input bit ru, input bit wu, input bit wbd,
                       input bit rdn, input bit wdn, input bit cs, input bit fv);
    flush = fl; pending_reads_up = ru; pending_writes_up = wu; write_balance_down = wbd;
    read_done = rdn; write_done = wdn; commit_store = cs; fence_valid = fv;
  endtask

  // Queue what the outputs must show after the coming edge, then clock and compare.
  task automatic tick(input string tag, input int rd, input int wr, input int wb, input bit err, input bit fr);
    push(tag, rd, wr, wb, err, fr);
    @(posedge clk_core);
    #1;
    check_pop();
  endtask

  initial begin
    rst_core_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_core);
    @(negedge clk_core) rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;
    push("reset", 0, 0, 0, 0, 0);
    check_pop();

    // Four reads issued, one up+done hold, then four completions.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0); tick("rd_up", i, 0, 0, 0, 0);
    end
    drive(0, 1, 0, 0, 1, 0, 0, 0); tick("rd_up_done_hold", 4, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0); tick("rd_done", i, 0, 0, 0, 0);
    end

    // Write balance: two commits, three ordinary writes (first one also issues a write), flush.
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick("wb_commit1", 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick("wb_commit2", 0, 0, 2, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0); tick("wb_down1", 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0); tick("wb_down2", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0); tick("wb_down3", 0, 1, -1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0); tick("wb_flush", 0, 1, 0, 0, 0);

    // Underflow at zero, then build 3/2/-1 and reset mid-cycle.
    drive(0, 0, 0, 0, 1, 0, 0, 0); tick("rd_underflow", 0, 1, 0, 1, 0);
    drive(0, 1, 1, 1, 0, 0, 0, 0); tick("build1", 1, 2, -1, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick("build2", 2, 2, -1, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick("build3", 3, 2, -1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_core_n = 1'b0;
    #2;
    push("reset_mid", 0, 0, 0, 0, 0);
    check_pop();
    @(negedge clk_core) rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;

    // Fence with two outstanding writes; completions in cycles 5 and 7, pulse in cycle 8.
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick("fw_w1", 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick("fw_w2", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("fw_c4", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("fw_c5", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1); tick("fw_c6", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("fw_c7", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1); tick("fw_c8_pulse", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("fw_c9", 0, 0, 0, 0, 0);

    // Fence with nothing outstanding still takes two cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("fidle_drain", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("fidle_pulse", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("fidle_after", 0, 0, 0, 0, 0);

    // Same fence scenario, flushed in cycle 6: no pulse, write counter keeps draining.
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick("ff_w1", 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick("ff_w2", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("ff_c4", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("ff_c5", 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1); tick("ff_c6", 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1); tick("ff_c7", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0); tick("ff_c8", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("ff_c9", 0, 0, 0, 0, 0);

    // Flush in the very cycle the drain would complete suppresses the pulse.
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick("fx_w1", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick("fx_drain", 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1); tick("fx_flush_done", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("fx_after", 0, 0, 0, 0, 0);

    // Sixteen read ups against MAX_PENDING=15: saturate, full, sticky error.
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      tick("rd_fill", (i > MAXP) ? MAXP : i, 0, 0, (i > MAXP), 0);
    end
    drive(0, 1, 0, 0, 1, 0, 0, 0); tick("rd_full_hold", 15, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0); tick("rd_unfull", 14, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
